// File: rtl/bimodal_btb_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus 2-bit saturating-counter PHT, trained from execute.
// Optional gshare indexing of the PHT is enabled by defining the macro GSHARE_EN.
module bimodal_btb_predictor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned GHR_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  output logic                  PredictTakenF_o,
  output logic [DATA_WIDTH-1:0] PredictedTargetF_o,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic                  BranchE_i,
  input  logic                  BranchTakenE_i
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam int unsigned TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

  if (GHR_BITS > INDEX_BITS) begin : g_bad_ghr
    $error("GHR_BITS must not exceed INDEX_BITS");
  end

  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];
  logic [1:0]            r_pht    [ENTRIES];

  logic [INDEX_BITS-1:0] w_idx_f, w_idx_e, w_pidx_f, w_pidx_e;
  logic [TAG_W-1:0]      w_tag_f, w_tag_e;
  logic                  w_hit_f, w_hit_e;
  logic [1:0]            w_pht_cur, w_pht_nxt;
  logic [3:0]            w_unused_pc_lsbs;

  // Instruction-aligned PCs: the two low bits carry no information.
  assign w_unused_pc_lsbs = {PCF_i[1:0], PCE_i[1:0]};

  assign w_idx_f = PCF_i[INDEX_BITS+1:2];
  assign w_tag_f = PCF_i[DATA_WIDTH-1:INDEX_BITS+2];
  assign w_idx_e = PCE_i[INDEX_BITS+1:2];
  assign w_tag_e = PCE_i[DATA_WIDTH-1:INDEX_BITS+2];

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;

  // Update side hashes with the history seen before this cycle's shift.
  assign w_pidx_f = w_idx_f ^ INDEX_BITS'(r_ghr);
  assign w_pidx_e = w_idx_e ^ INDEX_BITS'(r_ghr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (BranchE_i) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], BranchTakenE_i};
    end
  end
`else
  assign w_pidx_f = w_idx_f;
  assign w_pidx_e = w_idx_e;
`endif

  // Zero-latency lookup; reads pre-update state when execute writes the same entry.
  assign w_hit_f            = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign PredictTakenF_o    = w_hit_f && r_pht[w_pidx_f][1];
  assign PredictedTargetF_o = w_hit_f ? r_target[w_idx_f] : '0;

  assign w_hit_e   = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
  assign w_pht_cur = r_pht[w_pidx_e];

  // Fresh allocations start weakly taken; otherwise saturate toward the outcome.
  always_comb begin
    w_pht_nxt = w_pht_cur;
    if (BranchTakenE_i) begin
      if (!w_hit_e) begin
        w_pht_nxt = 2'b10;
      end else if (w_pht_cur != 2'b11) begin
        w_pht_nxt = w_pht_cur + 2'd1;
      end
    end else if (w_pht_cur != 2'b00) begin
      w_pht_nxt = w_pht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_pht[i]   <= 2'b01;
      end
    end else if (BranchE_i) begin
      r_pht[w_pidx_e] <= w_pht_nxt;
      // Taken branches allocate on miss and refresh the target on hit.
      if (BranchTakenE_i) begin
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= PCTargetE_i;
      end
    end
  end

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Directed bench for bimodal_btb_predictor; the GSHARE_EN build runs a history-alternation sequence instead.
module tb_bimodal_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF_i, PCE_i, PCTargetE_i;
  logic        BranchE_i, BranchTakenE_i;
  logic        PredictTakenF_o;
  logic [31:0] PredictedTargetF_o;

  int n_checks = 0;
  int n_errors = 0;

  bimodal_btb_predictor dut (
    .clk                (clk),
    .rst                (rst),
    .PCF_i              (PCF_i),
    .PredictTakenF_o    (PredictTakenF_o),
    .PredictedTargetF_o (PredictedTargetF_o),
    .PCE_i              (PCE_i),
    .PCTargetE_i        (PCTargetE_i),
    .BranchE_i          (BranchE_i),
    .BranchTakenE_i     (BranchTakenE_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one update strobe for exactly one rising edge; called just after a negedge.
  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    BranchE_i      = 1'b1;
    PCE_i          = pc;
    PCTargetE_i    = tgt;
    BranchTakenE_i = tk;
    @(negedge clk);
    BranchE_i = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_tgt);
    PCF_i = pc;
    #1;
    check({tag, ".taken"}, 32'(PredictTakenF_o), 32'(exp_tk));
    check({tag, ".target"}, PredictedTargetF_o, exp_tgt);
  endtask

  localparam logic [31:0] PC_A   = 32'hBFC0_0010;
  localparam logic [31:0] PC_AL  = 32'hBFC0_0110;
  localparam logic [31:0] PC_B   = 32'hBFC0_0020;
  localparam logic [31:0] PC_C   = 32'hBFC0_0030;
  localparam logic [31:0] PC_D   = 32'hBFC0_0050;
  localparam logic [31:0] PC_E   = 32'hBFC0_0060;
  localparam logic [31:0] T_A    = 32'hBFC0_0040;
  localparam logic [31:0] T_AL   = 32'hBFC0_0200;
  localparam logic [31:0] T_B    = 32'hBFC0_0080;
  localparam logic [31:0] T_C    = 32'hBFC0_00C0;

  initial begin
    rst            = 1'b1;
    BranchE_i      = 1'b0;
    BranchTakenE_i = 1'b0;
    PCE_i          = '0;
    PCTargetE_i    = '0;
    PCF_i          = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    look("reset_a", PC_A, 1'b0, 32'h0);

`ifdef GSHARE_EN
    // T N T N ... on one PC: after warm-up history alternates 42/21 and predictions follow it.
    for (int i = 0; i < 8; i++) train(PC_A, T_A, (i % 2) == 0);
    look("gs_t0", PC_A, 1'b1, T_A);
    train(PC_A, T_A, 1'b1);
    look("gs_n0", PC_A, 1'b0, T_A);
    train(PC_A, T_A, 1'b0);
    look("gs_t1", PC_A, 1'b1, T_A);
    train(PC_A, T_A, 1'b1);
    look("gs_n1", PC_A, 1'b0, T_A);
`else
    look("reset_b", PC_B, 1'b0, 32'h0);

    // Allocate, then walk the counter down to and past the floor.
    train(PC_A, T_A, 1'b1);
    look("alloc", PC_A, 1'b1, T_A);
    train(PC_A, T_A, 1'b0);
    look("nt1_01", PC_A, 1'b0, T_A);
    train(PC_A, T_A, 1'b0);
    look("nt2_00", PC_A, 1'b0, T_A);
    train(PC_A, T_A, 1'b0);
    look("floor", PC_A, 1'b0, T_A);

    // Counter climbs 01,10,11 and holds at 11.
    train(PC_A, T_A, 1'b1);
    look("t1_01", PC_A, 1'b0, T_A);
    train(PC_A, T_A, 1'b1);
    look("t2_10", PC_A, 1'b1, T_A);
    for (int i = 0; i < 3; i++) train(PC_A, T_A, 1'b1);
    look("sat_11", PC_A, 1'b1, T_A);
    train(PC_A, T_A, 1'b0);
    look("sat_nt_10", PC_A, 1'b1, T_A);
    train(PC_A, T_A, 1'b0);
    look("sat_nt_01", PC_A, 1'b0, T_A);

    // Alias at the same index: other tag misses, allocation evicts the old owner.
    look("alias_miss", PC_AL, 1'b0, 32'h0);
    train(PC_AL, T_AL, 1'b1);
    look("alias_alloc", PC_AL, 1'b1, T_AL);
    look("alias_evict", PC_A, 1'b0, 32'h0);

    // Same-cycle lookup and update: old state now, new state next cycle.
    PCF_i          = PC_B;
    BranchE_i      = 1'b1;
    PCE_i          = PC_B;
    PCTargetE_i    = T_B;
    BranchTakenE_i = 1'b1;
    #1;
    check("bypass_same.taken", 32'(PredictTakenF_o), 32'h0);
    @(negedge clk);
    BranchE_i = 1'b0;
    look("bypass_next", PC_B, 1'b1, T_B);

    // Strobe low: taken/target inputs must be ignored.
    BranchE_i      = 1'b0;
    PCE_i          = PC_E;
    PCTargetE_i    = 32'hDEAD_BEE0;
    BranchTakenE_i = 1'b1;
    @(negedge clk);
    look("no_strobe", PC_E, 1'b0, 32'h0);

    // Reset with an update pending clears everything and drops the update.
    train(PC_C, T_C, 1'b1);
    look("pre_rst_c", PC_C, 1'b1, T_C);
    rst = 1'b1;
    train(PC_D, 32'hBFC0_0300, 1'b1);
    rst = 1'b0;
    look("post_rst_b", PC_B, 1'b0, 32'h0);
    look("post_rst_c", PC_C, 1'b0, 32'h0);
    look("post_rst_al", PC_AL, 1'b0, 32'h0);
    look("dropped_upd", PC_D, 1'b0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
